exception_ctrl: RTL



---
 rtl/exception_ctrl_if.sv | 31 +++
 rtl/exception_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/exception_ctrl_if.sv
// CPU-side bundle for exception_ctrl: hazard/ID info, MEM-stage bus and entry pulses.
interface exception_ctrl_if;
    logic [31:0] PC;
    logic [31:0] ID_PC;
    logic        ID_Undef;
    logic [1:0]  ID_Jump;
    logic        ID_BranchTaken;
    logic        stall;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Interrupt;
    logic        Exception;
    logic [31:0] EPC;

    // CPU pipeline side
    modport master (
        output PC, ID_PC, ID_Undef, ID_Jump, ID_BranchTaken, stall,
               MemRead, MemWrite, Addr, WriteData,
        input  ReadData, Interrupt, Exception, EPC
    );

    // exception controller side
    modport slave (
        input  PC, ID_PC, ID_Undef, ID_Jump, ID_BranchTaken, stall,
               MemRead, MemWrite, Addr, WriteData,
        output ReadData, Interrupt, Exception, EPC
    );
endinterface

// File: rtl/exception_ctrl.sv
// Timer-driven interrupt and undefined-opcode exception source with EPC capture
// and a USER/KERNEL mask that re-opens when the PC returns to user space.
module exception_ctrl (
    input  logic             clk,
    input  logic             reset,
    exception_ctrl_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TCON_W = 3;
    localparam logic [DATA_W-1:0] TIMER_BASE = 32'h4000_0000;

    typedef enum logic {
        ST_USER   = 1'b0,
        ST_KERNEL = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   th_q, th_d;
    logic [DATA_W-1:0]   tl_q, tl_d;
    logic [TCON_W-1:0]   tcon_q, tcon_d;
    logic [DATA_W-1:0]   epc_q, epc_d;

    logic                win_hit_c;
    logic [1:0]          reg_sel_c;
    logic                wr_th_c, wr_tl_c, wr_tcon_c;
    logic                irq_req_c, safe_c;
    logic                interrupt_c, exception_c;
    logic [DATA_W-1:0]   read_data_c;
    logic                unused_ok;

    // Reads are not gated by the read strobe, so MemRead is accepted but unused.
    assign unused_ok = bus.MemRead;

    // Address decode of the 16-byte word-aligned register window.
    always_comb begin
        win_hit_c = (bus.Addr[DATA_W-1:4] == TIMER_BASE[DATA_W-1:4]) &&
                    (bus.Addr[1:0] == 2'b00);
        reg_sel_c = bus.Addr[3:2];
        wr_th_c   = bus.MemWrite && win_hit_c && (reg_sel_c == 2'd0);
        wr_tl_c   = bus.MemWrite && win_hit_c && (reg_sel_c == 2'd1);
        wr_tcon_c = bus.MemWrite && win_hit_c && (reg_sel_c == 2'd2);
    end

    // Combinational register readback; anything outside the window reads 0.
    always_comb begin
        read_data_c = '0;
        if (win_hit_c) begin
            case (reg_sel_c)
                2'd0:    read_data_c = th_q;
                2'd1:    read_data_c = tl_q;
                2'd2:    read_data_c = DATA_W'(tcon_q);
                default: read_data_c = epc_q;
            endcase
        end
    end

    // Timer: count/reload, then CPU writes override the counter and status.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (tcon_q[0]) begin
            if (tl_q == {DATA_W{1'b1}}) begin
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + DATA_W'(1);
            end
        end
        if (wr_th_c) begin
            th_d = bus.WriteData;
        end
        if (wr_tl_c) begin
            tl_d = bus.WriteData;
        end
        if (wr_tcon_c) begin
            tcon_d = bus.WriteData[TCON_W-1:0];
        end
    end

    // Entry decision and USER/KERNEL next state; exception wins over interrupt.
    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        exception_c = 1'b0;
        interrupt_c = 1'b0;
        irq_req_c   = tcon_q[2] & tcon_q[1];
        safe_c      = !bus.stall && (bus.ID_Jump == 2'b00) &&
                      !bus.ID_BranchTaken && !bus.ID_Undef;

        if (!reset && (state_q == ST_USER) && !bus.PC[31]) begin
            exception_c = bus.ID_Undef;
            interrupt_c = irq_req_c && safe_c && !bus.ID_Undef;
        end

        case (state_q)
            ST_USER: begin
                if (exception_c) begin
                    state_d = ST_KERNEL;
                    epc_d   = bus.ID_PC;
                end else if (interrupt_c) begin
                    state_d = ST_KERNEL;
                    epc_d   = bus.PC;
                end
            end
            ST_KERNEL: begin
                if (!bus.PC[31]) begin
                    state_d = ST_USER;
                end
            end
            default: state_d = ST_USER;
        endcase
    end

    // State and register flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_USER;
            th_q    <= '0;
            tl_q    <= '0;
            tcon_q  <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            th_q    <= th_d;
            tl_q    <= tl_d;
            tcon_q  <= tcon_d;
            epc_q   <= epc_d;
        end
    end

    assign bus.ReadData  = read_data_c;
    assign bus.Interrupt = interrupt_c;
    assign bus.Exception = exception_c;
    assign bus.EPC       = epc_q;

endmodule
